change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
//  Physical change-return back end for vendingMachine. Consumes its ReturnNickel/ReturnDime/ReturnTwoDimes
//  request pulses, queues them as owed-coin counts and drives nickel/dime hopper ejectors one coin at a time.
//  Each ejection is confirmed by the coin-drop sensor; tracks hopper inventory, substitutes 2 nickels for a
//  dime when the dime hopper is empty, and flags jams and short change.
// PARAMETERS
//  INV_W        6   width of hopper inventory counters (saturate at 2**INV_W-1)
//  PEND_W       4   width of owed-coin counters pendN/pendD (saturate at 2**PEND_W-1)
//  NICKEL_INIT  8   nickel inventory loaded at reset
//  DIME_INIT    8   dime inventory loaded at reset
//  EJECT_CYC    4   cycles the eject solenoid is held high per coin (>=1)
//  ACK_TO       16  max cycles in WAIT for coinSense before declaring a jam (>=1)
// PORTS
//  clk             in   1       system clock, all logic on posedge
//  reset           in   1       synchronous, active-low; reset==0 at posedge clk resets block
//  ReturnNickel    in   1       1-cycle request: owe 1 nickel
//  ReturnDime      in   1       1-cycle request: owe 1 dime
//  ReturnTwoDimes  in   1       1-cycle request: owe 2 dimes
//  coinSense       in   1       coin-drop sensor; high >=1 cycle when a coin falls
//  refillN/refillD in   1       1-cycle pulse: +1 coin loaded in nickel/dime hopper
//  clearJam        in   1       1-cycle pulse: leave JAM state
//  ejectNickel     out  1       nickel solenoid drive
//  ejectDime       out  1       dime solenoid drive
//  busy            out  1       high whenever pendN!=0 or pendD!=0 or state!=IDLE
//  shortChange     out  1       owed coins exist but neither hopper can pay them
//  jam             out  1       high in JAM state
//  pendOverflow    out  1       sticky: a request saturated a pending counter
//  nickelCount     out  INV_W   current nickel inventory
//  dimeCount       out  INV_W   current dime inventory
// BEHAVIOUR
//  Reset: state=IDLE, pendN=pendD=0, nickelCount=NICKEL_INIT, dimeCount=DIME_INIT, all 1-bit outputs 0.
//   Reset mid-ejection drops solenoid next edge and discards all owed coins.
//  Requests: each cycle pendN += ReturnNickel; pendD += ReturnDime + 2*ReturnTwoDimes (all may coincide);
//   combined with any same-cycle decrement (net update); result saturates at max, sets pendOverflow.
//  Refill: counts +1 on pulse, saturating; refill and same-cycle decrement net out.
//  FSM states: IDLE, EJECT_N, WAIT_N, EJECT_D, WAIT_D, JAM. Priority in IDLE (dimes first):
//   pendD>0 & dimeCount>0              -> EJECT_D
//   pendD>0 & dimeCount==0 & nickelCount>=2 -> substitute: pendD-=1, pendN+=2, stay IDLE (1 cycle)
//   pendN>0 & nickelCount>0            -> EJECT_N
//   else if owed coins remain          -> shortChange=1 (combinational from IDLE+counts), stay IDLE
//  EJECT_x: solenoid high exactly EJECT_CYC cycles, then WAIT_x (solenoid low).
//  WAIT_x: coinSense==1 -> pend_x-=1, count_x-=1, -> IDLE. ACK_TO cycles without it -> JAM.
//   coinSense outside WAIT_x is ignored.
//  JAM: jam=1, solenoids low, requests/refills still accumulate; clearJam -> IDLE, owed coin
//   not decremented (retried).
//  Latency: request at edge k visible in pend at k+1; IDLE leaves at edge k+1;
//   ejectDime high from cycle k+2 to k+1+EJECT_CYC.
// TESTING
//  1 reset, ReturnDime pulse, coinSense 2 cycles after eject falls -> ejectDime high 4 cycles,
//    dimeCount 8->7, busy falls.
//  2 ReturnNickel+ReturnTwoDimes same cycle -> 2 dimes then 1 nickel ejected, final counts N=7 D=6.
//  3 dimeCount=0, ReturnDime -> substitution, 2 nickel ejections, nickelCount 8->6, shortChange stays 0.
//  4 both hoppers 0, ReturnNickel -> shortChange=1; refillN pulse -> nickel ejected, shortChange=0.
//  5 no coinSense for 16 WAIT cycles -> jam=1; clearJam -> same coin re-ejected, pendN unchanged until ack.
//  6 20 ReturnDime pulses while jammed -> pendD=15, pendOverflow=1; reset=0 mid-EJECT_D
//    -> ejectDime=0 next edge, counts reloaded to 8.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Signal bundle between the vending controller side and the change dispenser.
// The master drives requests, sensor and maintenance pulses; the slave drives solenoids and status.
interface change_dispenser_if #(
  parameter int INV_W = 6
);
  logic             ReturnNickel;
  logic             ReturnDime;
  logic             ReturnTwoDimes;
  logic             coinSense;
  logic             refillN;
  logic             refillD;
  logic             clearJam;
  logic             ejectNickel;
  logic             ejectDime;
  logic             busy;
  logic             shortChange;
  logic             jam;
  logic             pendOverflow;
  logic [INV_W-1:0] nickelCount;
  logic [INV_W-1:0] dimeCount;

  modport master (
    output ReturnNickel, ReturnDime, ReturnTwoDimes, coinSense, refillN, refillD, clearJam,
    input  ejectNickel, ejectDime, busy, shortChange, jam, pendOverflow, nickelCount, dimeCount
  );

  modport slave (
    input  ReturnNickel, ReturnDime, ReturnTwoDimes, coinSense, refillN, refillD, clearJam,
    output ejectNickel, ejectDime, busy, shortChange, jam, pendOverflow, nickelCount, dimeCount
  );
endinterface

// File: rtl/change_dispenser.sv
// Change-return back end: queues owed nickels/dimes and ejects them one coin at a time,
// confirming each drop on the coin sensor, tracking hopper inventory and flagging jams.
module change_dispenser #(
  parameter int INV_W       = 6,
  parameter int PEND_W      = 4,
  parameter int NICKEL_INIT = 8,
  parameter int DIME_INIT   = 8,
  parameter int EJECT_CYC   = 4,
  parameter int ACK_TO      = 16
) (
  input logic                clk,
  input logic                reset,
  change_dispenser_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EJECT_N = 3'd1,
    WAIT_N  = 3'd2,
    EJECT_D = 3'd3,
    WAIT_D  = 3'd4,
    JAM     = 3'd5
  } state_t;

  localparam int PW2     = PEND_W + 2;
  localparam int IW1     = INV_W + 1;
  localparam int TMR_MAX = (EJECT_CYC > ACK_TO) ? EJECT_CYC : ACK_TO;
  localparam int TMR_W   = $clog2(TMR_MAX + 1) + 1;

  localparam logic [PW2-1:0]   PEND_MAX   = {2'b00, {PEND_W{1'b1}}};
  localparam logic [IW1-1:0]   INV_MAX    = {1'b0, {INV_W{1'b1}}};
  localparam logic [PW2-1:0]   PEND_TWO   = {{PEND_W{1'b0}}, 2'b10};
  localparam logic [PW2-1:0]   PEND_NONE  = {PW2{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE    = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] EJECT_LAST = TMR_W'(EJECT_CYC - 1);
  localparam logic [TMR_W-1:0] ACK_LAST   = TMR_W'(ACK_TO - 1);
  localparam logic [INV_W-1:0] INV_TWO    = {{(INV_W-2){1'b0}}, 2'b10};

  // Clamp a widened pending-count sum to the counter range.
  function automatic logic [PEND_W-1:0] sat_pend(input logic [PW2-1:0] v);
    if (v > PEND_MAX) sat_pend = PEND_MAX[PEND_W-1:0];
    else              sat_pend = v[PEND_W-1:0];
  endfunction

  // Clamp a widened inventory sum to the counter range.
  function automatic logic [INV_W-1:0] sat_inv(input logic [IW1-1:0] v);
    if (v > INV_MAX) sat_inv = INV_MAX[INV_W-1:0];
    else             sat_inv = v[INV_W-1:0];
  endfunction

  state_t             state_r;
  logic [TMR_W-1:0]   tmr_r;
  logic [PEND_W-1:0]  pend_n_r, pend_d_r;
  logic [INV_W-1:0]   nickel_cnt_r, dime_cnt_r;
  logic               eject_n_r, eject_d_r, jam_r, overflow_r;

  logic               can_d_s, can_sub_s, can_n_s, idle_s, owed_s;
  logic               sub_s, ack_n_s, ack_d_s, ovf_s;
  logic [PW2-1:0]     pend_n_sum_s, pend_d_sum_s;
  logic [IW1-1:0]     nickel_sum_s, dime_sum_s;

  // Dispatch decisions and net next values for the pending and inventory counters.
  always_comb begin
    idle_s    = (state_r == IDLE);
    owed_s    = (pend_n_r != {PEND_W{1'b0}}) || (pend_d_r != {PEND_W{1'b0}});
    can_d_s   = (pend_d_r != {PEND_W{1'b0}}) && (dime_cnt_r != {INV_W{1'b0}});
    can_sub_s = (pend_d_r != {PEND_W{1'b0}}) && (dime_cnt_r == {INV_W{1'b0}})
                && (nickel_cnt_r >= INV_TWO);
    can_n_s   = (pend_n_r != {PEND_W{1'b0}}) && (nickel_cnt_r != {INV_W{1'b0}});
    sub_s     = idle_s && can_sub_s;
    ack_n_s   = (state_r == WAIT_N) && bus.coinSense;
    ack_d_s   = (state_r == WAIT_D) && bus.coinSense;

    pend_n_sum_s = {2'b00, pend_n_r} + PW2'(bus.ReturnNickel)
                   + (sub_s ? PEND_TWO : PEND_NONE) - PW2'(ack_n_s);
    pend_d_sum_s = {2'b00, pend_d_r} + PW2'(bus.ReturnDime)
                   + {{PEND_W{1'b0}}, bus.ReturnTwoDimes, 1'b0}
                   - PW2'(sub_s) - PW2'(ack_d_s);
    ovf_s        = (pend_n_sum_s > PEND_MAX) || (pend_d_sum_s > PEND_MAX);

    nickel_sum_s = {1'b0, nickel_cnt_r} + IW1'(bus.refillN) - IW1'(ack_n_s);
    dime_sum_s   = {1'b0, dime_cnt_r}   + IW1'(bus.refillD) - IW1'(ack_d_s);
  end

  // Owed-coin queues, hopper inventory and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_n_r     <= {PEND_W{1'b0}};
      pend_d_r     <= {PEND_W{1'b0}};
      nickel_cnt_r <= INV_W'(NICKEL_INIT);
      dime_cnt_r   <= INV_W'(DIME_INIT);
      overflow_r   <= 1'b0;
    end else begin
      pend_n_r     <= sat_pend(pend_n_sum_s);
      pend_d_r     <= sat_pend(pend_d_sum_s);
      nickel_cnt_r <= sat_inv(nickel_sum_s);
      dime_cnt_r   <= sat_inv(dime_sum_s);
      overflow_r   <= overflow_r | ovf_s;
    end
  end

  // Ejection FSM; the solenoid and jam outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      tmr_r     <= {TMR_W{1'b0}};
      eject_n_r <= 1'b0;
      eject_d_r <= 1'b0;
      jam_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tmr_r <= {TMR_W{1'b0}};
          if (can_d_s) begin
            state_r   <= EJECT_D;
            eject_d_r <= 1'b1;
          end else if (can_sub_s) begin
            state_r <= IDLE;
          end else if (can_n_s) begin
            state_r   <= EJECT_N;
            eject_n_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        EJECT_N, EJECT_D: begin
          if (tmr_r == EJECT_LAST) begin
            state_r   <= (state_r == EJECT_N) ? WAIT_N : WAIT_D;
            eject_n_r <= 1'b0;
            eject_d_r <= 1'b0;
            tmr_r     <= {TMR_W{1'b0}};
          end else begin
            tmr_r <= tmr_r + TMR_ONE;
          end
        end
        WAIT_N, WAIT_D: begin
          if (bus.coinSense) begin
            state_r <= IDLE;
          end else if (tmr_r == ACK_LAST) begin
            state_r <= JAM;
            jam_r   <= 1'b1;
          end else begin
            tmr_r <= tmr_r + TMR_ONE;
          end
        end
        JAM: begin
          if (bus.clearJam) begin
            state_r <= IDLE;
            jam_r   <= 1'b0;
          end else begin
            state_r <= JAM;
          end
        end
        default: begin
          state_r   <= IDLE;
          eject_n_r <= 1'b0;
          eject_d_r <= 1'b0;
          jam_r     <= 1'b0;
        end
      endcase
    end
  end

  // shortChange and busy follow the registers directly so they track the same cycle as the counts.
  assign bus.ejectNickel  = eject_n_r;
  assign bus.ejectDime    = eject_d_r;
  assign bus.jam          = jam_r;
  assign bus.pendOverflow = overflow_r;
  assign bus.nickelCount  = nickel_cnt_r;
  assign bus.dimeCount    = dime_cnt_r;
  assign bus.busy         = owed_s || !idle_s;
  assign bus.shortChange  = idle_s && owed_s && !(can_d_s || can_sub_s || can_n_s);

endmodule
